// File: rtl/pep9_fetch_unit.sv
// Pep9 instruction fetch: byte-serial fetch of specifier + operand, valid/ready issue, PC redirect.
// Optional macro PEP9_FETCH_STOP_HALT_EN: an accepted STOP (8'h00) parks the unit in HALT.
module pep9_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Sysclk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_valid,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  InstructionSpecifier,
  output logic [15:0] OperandSpecifier,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    SPEC  = 3'd0,
    OPHI  = 3'd1,
    OPLO  = 3'd2,
    ISSUE = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t      state_reg;
  logic [15:0] pc_reg;
  logic [7:0]  spec_reg;
  logic [15:0] oprnd_reg;

  logic fetching;
  logic xfer;
  logic rdata_unary;
  logic accept;

  assign fetching    = (state_reg == SPEC) || (state_reg == OPHI) || (state_reg == OPLO);
  assign mem_req     = fetching && !reset;
  assign mem_addr    = pc_reg;
  assign xfer        = mem_req && mem_valid;
  assign rdata_unary = (mem_rdata <= 8'h11) || (mem_rdata == 8'h26) || (mem_rdata == 8'h27);
  assign accept      = (state_reg == ISSUE) && instr_ready;

  assign InstructionSpecifier = spec_reg;
  assign OperandSpecifier     = oprnd_reg;
  assign instr_valid          = (state_reg == ISSUE);
  assign pc                   = pc_reg;

`ifdef PEP9_FETCH_STOP_HALT_EN
  assign halted = (state_reg == HALT);
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge Sysclk) begin
    if (reset) begin
      state_reg <= SPEC;
      pc_reg    <= RESET_PC;
      spec_reg  <= 8'h00;
      oprnd_reg <= 16'h0000;
    end else if (pc_load && (state_reg != HALT)) begin
      // Redirect wins over any byte landing this cycle; the byte and its PC bump are dropped.
      pc_reg    <= pc_load_value;
      state_reg <= SPEC;
    end else begin
      case (state_reg)
        SPEC: begin
          if (xfer) begin
            spec_reg <= mem_rdata;
            pc_reg   <= pc_reg + 16'd1;
            if (rdata_unary) begin
              oprnd_reg <= 16'h0000;
              state_reg <= ISSUE;
            end else begin
              state_reg <= OPHI;
            end
          end
        end
        OPHI: begin
          if (xfer) begin
            oprnd_reg[15:8] <= mem_rdata;
            pc_reg          <= pc_reg + 16'd1;
            state_reg       <= OPLO;
          end
        end
        OPLO: begin
          if (xfer) begin
            oprnd_reg[7:0] <= mem_rdata;
            pc_reg         <= pc_reg + 16'd1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
`ifdef PEP9_FETCH_STOP_HALT_EN
            state_reg <= (spec_reg == 8'h00) ? HALT : SPEC;
`else
            state_reg <= SPEC;
`endif
          end
        end
        HALT: state_reg <= HALT;
        default: state_reg <= SPEC;
      endcase
    end
  end

endmodule

// File: doc/pep9_fetch_unit.md
# pep9_fetch_unit

Instruction fetch stage placed directly upstream of the Pep9 CPU datapath/control top. It reads instruction bytes from a byte-wide memory port at the program counter, distinguishes unary (1-byte) from non-unary (3-byte) Pep9 instructions, and presents a complete instruction specifier plus 16-bit operand specifier to the CPU with a valid/ready handshake. It owns the PC, accepts PC redirects from the CPU for branches, calls and returns, and halts on STOP.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- Sysclk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_req  output  1  fetch request; mem_addr is valid while high.
- mem_addr  output  16  byte address being fetched; equals current PC.
- mem_valid  input  1  memory has data; a byte transfers in any cycle with mem_req && mem_valid.
- mem_rdata  input  8  fetched byte; sampled only on a transfer.
- InstructionSpecifier  output  8  opcode byte of the issued instruction.
- OperandSpecifier  output  16  operand (high byte first in memory); 16'h0000 for unary.
- instr_valid  output  1  instruction outputs are valid and stable.
- instr_ready  input  1  CPU accepts the instruction in a cycle with instr_valid && instr_ready.
- pc_load  input  1  one-cycle PC redirect request.
- pc_load_value  input  16  redirect target.
- pc  output  16  current PC (next byte to fetch).
- halted  output  1  STOP issued and accepted; fetching stopped.

## Operation
- States: SPEC, OPHI, OPLO, ISSUE, HALT. Reset state SPEC.
- mem_req = (state ∈ {SPEC, OPHI, OPLO}) && !reset. mem_addr = pc.
- Each transfer: captures mem_rdata into the register for the current state; pc <= pc + 1, 16-bit wrap (16'hFFFF -> 16'h0000).
- SPEC transfer: captures opcode; if unary -> ISSUE with OperandSpecifier cleared to 0; else -> OPHI.
- Unary opcodes: 8'h00-8'h11 and 8'h26-8'h27. All others are non-unary.
- OPHI transfer -> OPLO (captures OperandSpecifier[15:8]); OPLO transfer -> ISSUE (captures [7:0]).
- ISSUE: instr_valid = 1; outputs held until accepted. On accept: STOP (8'h00) -> HALT (see Configuration), otherwise -> SPEC.
- HALT: mem_req = 0, instr_valid = 0, halted = 1; left only by reset. pc_load ignored.
- pc_load (not in HALT): pc <= pc_load_value; state -> SPEC; any byte transferring in that same cycle is discarded (its pc increment suppressed); an unaccepted instruction in ISSUE is dropped. If pc_load coincides with an accept in ISSUE, the accept completes and the redirect still applies.
- Memory slave must tolerate mem_addr changing while mem_req stays high; no request is committed until mem_valid.
- reset mid-operation: discards all partial fetches and any pending issue in the same edge.

## Timing
- Reset values: pc = RESET_PC, InstructionSpecifier = 8'h00, OperandSpecifier = 16'h0000, instr_valid = 0, halted = 0, mem_req = 0.
- mem_valid may be high in the same cycle as mem_req (zero wait) or any later cycle; mem_addr held stable until transfer or pc_load.
- Zero-wait memory: unary instruction valid 1 cycle after its specifier transfer cycle; non-unary valid 1 cycle after the third transfer (3 fetch cycles + issue).
- Accept in ISSUE at cycle n -> mem_req high at n+1 with mem_addr = next PC. Sustained zero-wait, always-ready rate: unary 1 per 2 cycles, non-unary 1 per 4.
- instr_valid never drops without accept, except on pc_load or reset.

## Configuration
- PEP9_FETCH_STOP_HALT_EN defined: accepted STOP enters HALT, halted = 1.
- Undefined: STOP is issued like any unary instruction, fetch continues at pc; HALT unreachable, halted tied 0.

## Test plan
- Reset with RESET_PC = 16'h0100, zero-wait memory holding 8'h08 at 16'h0100, ready = 1 -> mem_addr 16'h0100, one cycle later instr_valid with InstructionSpecifier 8'h08, OperandSpecifier 16'h0000, pc 16'h0101.
- Bytes C0 12 34 at 16'h0000, mem_valid delayed 2 cycles per byte -> InstructionSpecifier 8'hC0, OperandSpecifier 16'h1234, pc 16'h0003; outputs held stable for 4 cycles with instr_ready = 0, then SPEC fetch at 16'h0003.
- pc = 16'hFFFF fetching unary 8'h06 -> pc wraps to 16'h0000, next mem_addr 16'h0000.
- pc_load = 1 with value 16'h0200 during OPHI transfer cycle -> byte discarded, next mem_addr 16'h0200, no instr_valid for the aborted instruction.
- STOP (8'h00) accepted, macro defined -> halted = 1, mem_req = 0, pc_load ignored; reset restores pc = RESET_PC, halted = 0. Macro undefined -> fetch continues at next address.
- reset asserted during OPLO wait -> next cycle all outputs at reset values, mem_req 0 while reset high.
